pixel_stream_capture: RTL and testbench
=======================================

Name: pixel_stream_capture

Overview:
Sink end of the processed-pixel stream. Accepts 24-bit RGB pixels over a valid/ready handshake and writes one full frame, in raster order, into an internal frame buffer. Tracks column/row position and signals frame completion. Exposes a registered read port so a host or bench can inspect the captured frame.

Parameters:
IMAGE_WIDTH, 512, pixels per row
IMAGE_HEIGHT, 512, rows per frame
IMAGE_SIZE, IMAGE_WIDTH*IMAGE_HEIGHT, frame-buffer depth in 24-bit words
(derived localparams: AW=$clog2(IMAGE_SIZE), XW=$clog2(IMAGE_WIDTH), YW=$clog2(IMAGE_HEIGHT))

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset: synchronous, active-high
arm  in  1  start capture of one frame (level sampled; acted on in IDLE only)
abort  in  1  cancel capture in progress
in_pixel  in  24  {R[23:16],G[15:8],B[7:0]}
in_valid  in  1  in_pixel valid
in_ready  out  1  registered; capture can accept a pixel
busy  out  1  high in CAPTURE
frame_done  out  1  one-cycle pulse: full frame captured
overrun  out  1  sticky: in_valid seen while not capturing
x_count  out  XW  column of the next pixel to be written
y_count  out  YW  row of the next pixel to be written
rd_addr  in  AW  read address into the frame buffer
rd_data  out  24  frame-buffer data, 1-cycle latency
checksum  out  32  see Optional Feature

Behaviour:
- Reset: state=IDLE, in_ready=0, busy=0, frame_done=0, overrun=0, x_count=0, y_count=0, write address=0, rd_data=0, checksum=0. Frame-buffer contents are not reset.
- States: IDLE, CAPTURE, DONE.
- IDLE: in_ready=0. If arm=1: clear write address, x_count, y_count and overrun; go to CAPTURE. in_ready=1 from the next cycle.
- CAPTURE: transfer occurs on a cycle where in_valid && in_ready.
  - On transfer: mem[addr]<=in_pixel; addr+1.
  - x_count increments. At IMAGE_WIDTH-1 it wraps to 0 and y_count increments.
  - No transfer: all counters hold.
  - arm is ignored.
- Last pixel (transfer at addr==IMAGE_SIZE-1): go to DONE. in_ready<=0 at the same edge, so no extra pixel is accepted. addr, x_count and y_count wrap to 0.
- DONE: frame_done=1 for exactly this one cycle. Always returns to IDLE next cycle. arm is ignored in DONE.
- abort in CAPTURE: go to IDLE next edge, in_ready<=0, no frame_done. A transfer in the same cycle as abort is still written; counters keep their partial values. abort in IDLE or DONE has no effect.
- overrun: set when in_valid=1 and state!=CAPTURE. The pixel is dropped. Cleared only by rst or by arm in IDLE. arm and in_valid in the same IDLE cycle: arm wins, overrun ends at 0.
- busy = (state==CAPTURE), registered.
- Read port: rd_data<=mem[rd_addr] every cycle, in any state. Read and write to the same address in the same cycle returns the old data.
- rst mid-capture: immediately returns to IDLE with reset values. Partial frame data stays in memory.

Optional Feature:
Macro PIXEL_CAPTURE_CHECKSUM_EN.
- Defined: checksum is a 32-bit register. It is cleared on arm (in IDLE) and adds {8'h00,in_pixel} on every transfer, wrapping mod 2^32. It holds its value after DONE/abort until the next arm.
- Undefined: checksum is tied to 32'h0 and no adder is synthesised.

Test Plan:
- IMAGE_WIDTH=4, IMAGE_HEIGHT=4; arm, then 16 pixels value i*0x010101 with in_valid held high -> frame_done pulses once, one cycle after the 16th transfer. in_ready=0 thereafter. Reading addr 0..15 returns i*0x010101 one cycle after rd_addr is applied.
- Same frame with in_valid toggling 1,0,1,0 -> identical memory contents. x_count/y_count read (1,0) after the first transfer, and (0,1) after the 4th transfer.
- in_valid=1 in IDLE without arm -> overrun=1 and memory unchanged. Next arm -> overrun=0. arm and in_valid in the same IDLE cycle -> overrun stays 0.
- After 6 transfers, assert abort -> busy falls next cycle, no frame_done, x_count=2, y_count=1. Re-arm and send a full frame -> normal completion, counters restarted at 0.
- rst asserted after 10 transfers -> all outputs at reset values next cycle. Memory words 0..9 still readable via rd_data.
- With PIXEL_CAPTURE_CHECKSUM_EN, 16 pixels 0x000001..0x000010 -> checksum=136 (0x88) at frame_done. Without the macro, checksum=0 throughout.

Source files
------------

// File: rtl/pixel_stream_capture.sv
// -----------------------------------------------------------------------------
// pixel_stream_capture
//
// Sink end of the processed-pixel stream. Accepts 24-bit RGB pixels over a
// valid/ready handshake and writes exactly one frame, in raster order, into an
// internal frame buffer. Tracks the column/row of the next pixel, pulses
// frame_done when the frame is complete and offers a registered read port.
//
// Optional feature macro: PIXEL_CAPTURE_CHECKSUM_EN
//   defined   -> checksum accumulates {8'h00,in_pixel} over every transfer
//   undefined -> checksum is tied to zero and no adder exists
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   arm         start capture of one frame (acted on in IDLE only)
//   abort       cancel a capture in progress
//   in_pixel    {R[23:16],G[15:8],B[7:0]}
//   in_valid    in_pixel valid
//   in_ready    registered; capture can accept a pixel
//   busy        registered; high while capturing
//   frame_done  one-cycle pulse when the full frame has been captured
//   overrun     sticky; in_valid seen while not capturing (pixel dropped)
//   x_count     column of the next pixel to be written
//   y_count     row of the next pixel to be written
//   rd_addr     frame-buffer read address
//   rd_data     frame-buffer read data, one cycle latency
//   checksum    running pixel sum (see macro above)
// -----------------------------------------------------------------------------
module pixel_stream_capture #(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int AW = $clog2(IMAGE_SIZE),
  localparam int XW = $clog2(IMAGE_WIDTH),
  localparam int YW = $clog2(IMAGE_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          abort,
  input  logic [23:0]   in_pixel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun,
  output logic [XW-1:0] x_count,
  output logic [YW-1:0] y_count,
  input  logic [AW-1:0] rd_addr,
  output logic [23:0]   rd_data,
  output logic [31:0]   checksum
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [XW-1:0] X_LAST    = XW'(IMAGE_WIDTH - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(IMAGE_SIZE - 1);

  logic [1:0]    state_r;
  logic [AW-1:0] wr_addr_r;
  logic [23:0]   mem_r [IMAGE_SIZE];

  logic transfer_s;
  logic arm_start_s;
  logic last_s;

  // in_ready is only ever set in CAPTURE; the state term keeps the write
  // enable safe even if the two registers were ever to disagree.
  assign transfer_s  = in_valid && in_ready && (state_r == ST_CAPTURE);
  assign arm_start_s = arm && (state_r == ST_IDLE);
  assign last_s      = transfer_s && (wr_addr_r == ADDR_LAST);

  // Capture control: state, handshake flags, position counters, overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      x_count    <= '0;
      y_count    <= '0;
      wr_addr_r  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // arm wins over a same-cycle in_valid, so overrun ends cleared
          if (arm) begin
            state_r   <= ST_CAPTURE;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            wr_addr_r <= '0;
            x_count   <= '0;
            y_count   <= '0;
            overrun   <= 1'b0;
          end else if (in_valid) begin
            overrun <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (transfer_s) begin
            wr_addr_r <= last_s ? '0 : wr_addr_r + AW'(1);
            if (x_count == X_LAST) begin
              x_count <= '0;
              // forced wrap on the last pixel keeps non-power-of-two
              // heights correct
              y_count <= last_s ? '0 : y_count + YW'(1);
            end else begin
              x_count <= x_count + XW'(1);
            end
          end
          // abort takes priority: a frame aborted on its last pixel does
          // not report completion
          if (abort) begin
            state_r  <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (last_s) begin
            state_r    <= ST_DONE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          if (in_valid) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Frame-buffer write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (transfer_s) begin
      mem_r[wr_addr_r] <= in_pixel;
    end
  end

  // Registered read port; a same-address write returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 24'h00_0000;
    end else begin
      rd_data <= mem_r[rd_addr];
    end
  end

`ifdef PIXEL_CAPTURE_CHECKSUM_EN
  logic [31:0] checksum_r;

  // Running frame checksum, restarted by arm and held after the frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_r <= 32'h0000_0000;
    end else if (arm_start_s) begin
      checksum_r <= 32'h0000_0000;
    end else if (transfer_s) begin
      checksum_r <= checksum_r + {8'h00, in_pixel};
    end
  end

  assign checksum = checksum_r;
`else
  logic unused_arm_start_s;
  assign unused_arm_start_s = arm_start_s;
  assign checksum = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pixel_stream_capture.sv
// -----------------------------------------------------------------------------
// tb_pixel_stream_capture
//
// Self-checking bench for pixel_stream_capture with a 4x4 frame. Frame
// transfers are table-driven (one record per cycle with expected counters and
// flags); frame-buffer readback goes through a scoreboard queue filled when
// the read address is driven and drained when rd_data is due. Overrun, abort,
// checksum and mid-frame reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_pixel_stream_capture;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        abort;
  logic [23:0] in_pixel;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic [1:0]  x_count;
  logic [1:0]  y_count;
  logic [3:0]  rd_addr;
  logic [23:0] rd_data;
  logic [31:0] checksum;

  pixel_stream_capture #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .abort      (abort),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .x_count    (x_count),
    .y_count    (y_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [23:0] pix;
    logic [1:0]  exp_x;
    logic [1:0]  exp_y;
    logic        exp_done;
    logic        exp_ready;
  } vec_t;

  vec_t        vecs [40];
  int          n_vecs;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] exp_mem [N];
  logic [23:0] rd_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build one frame's records; with toggle, every other cycle is idle and
  // carries a junk pixel that must never reach memory.
  task automatic build(input bit toggle, input logic [23:0] base, input logic [23:0] step);
    int t = 0;
    int j = 0;
    n_vecs = 0;
    while (t < N) begin
      if (toggle && (j % 2 == 1)) begin
        vecs[n_vecs].valid = 1'b0;
        vecs[n_vecs].pix   = 24'hAB_CDEF;
      end else begin
        vecs[n_vecs].valid = 1'b1;
        vecs[n_vecs].pix   = base + 24'(t) * step;
        t++;
      end
      vecs[n_vecs].exp_x     = 2'(t % W);
      vecs[n_vecs].exp_y     = 2'((t / W) % H);
      vecs[n_vecs].exp_done  = vecs[n_vecs].valid && (t == N);
      vecs[n_vecs].exp_ready = (t < N);
      n_vecs++;
      j++;
    end
    // DONE -> IDLE cycle
    vecs[n_vecs].valid     = 1'b0;
    vecs[n_vecs].pix       = 24'h00_0000;
    vecs[n_vecs].exp_x     = 2'd0;
    vecs[n_vecs].exp_y     = 2'd0;
    vecs[n_vecs].exp_done  = 1'b0;
    vecs[n_vecs].exp_ready = 1'b0;
    n_vecs++;
  endtask

  // Apply the table to an armed DUT and compare every cycle.
  task automatic run_table(input string tag);
    int          addr = 0;
    logic [31:0] cs   = 32'h0000_0000;
    logic [31:0] exp_cs;
    for (int i = 0; i < n_vecs; i++) begin
      in_valid = vecs[i].valid;
      in_pixel = vecs[i].pix;
      if (vecs[i].valid) begin
        exp_mem[addr] = vecs[i].pix;
        cs = cs + {8'h00, vecs[i].pix};
        addr++;
      end
      tick();
      check($sformatf("%s r%0d x_count", tag, i), 32'(x_count), 32'(vecs[i].exp_x));
      check($sformatf("%s r%0d y_count", tag, i), 32'(y_count), 32'(vecs[i].exp_y));
      check($sformatf("%s r%0d frame_done", tag, i), 32'(frame_done), 32'(vecs[i].exp_done));
      check($sformatf("%s r%0d in_ready", tag, i), 32'(in_ready), 32'(vecs[i].exp_ready));
      if (vecs[i].exp_done) begin
`ifdef PIXEL_CAPTURE_CHECKSUM_EN
        exp_cs = cs;
`else
        exp_cs = 32'h0000_0000;
`endif
        check($sformatf("%s checksum", tag), checksum, exp_cs);
      end
    end
    in_valid = 1'b0;
    check($sformatf("%s busy after", tag), 32'(busy), 32'd0);
  endtask

  task automatic arm_it(input string tag);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check($sformatf("%s busy", tag), 32'(busy), 32'd1);
    check($sformatf("%s in_ready", tag), 32'(in_ready), 32'd1);
  endtask

  // Scoreboard readback: expectation queued with the address, popped a cycle later.
  task automatic readback(input string tag, input int n);
    for (int a = 0; a < n; a++) begin
      rd_addr = 4'(a);
      rd_q.push_back(exp_mem[a]);
      tick();
      check($sformatf("%s rd[%0d]", tag, a), 32'(rd_data), 32'(rd_q.pop_front()));
    end
  endtask

  task automatic send(input logic [23:0] pix, input int addr);
    in_valid = 1'b1;
    in_pixel = pix;
    exp_mem[addr] = pix;
    tick();
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_pixel = 24'h00_0000; rd_addr = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset x_count", 32'(x_count), 32'd0);
    check("reset y_count", 32'(y_count), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    check("reset checksum", checksum, 32'd0);

    // Full frame, in_valid held high
    arm_it("f1");
    build(1'b0, 24'h00_0000, 24'h01_0101);
    run_table("f1");
    readback("f1", N);

    // Same frame, in_valid toggling
    arm_it("f2");
    build(1'b1, 24'h00_0000, 24'h01_0101);
    run_table("f2");
    readback("f2", N);
    check("f2 overrun", 32'(overrun), 32'd0);

    // Overrun in IDLE, cleared by arm; arm beats same-cycle in_valid
    in_valid = 1'b1; in_pixel = 24'hDE_AD00;
    tick();
    in_valid = 1'b0;
    check("ovr set", 32'(overrun), 32'd1);
    check("ovr in_ready", 32'(in_ready), 32'd0);
    tick();
    check("ovr sticky", 32'(overrun), 32'd1);
    readback("ovr mem", N);
    arm_it("ovr arm");
    check("ovr cleared", 32'(overrun), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b1;
    tick();
    check("ovr set2", 32'(overrun), 32'd1);
    arm = 1'b1;
    tick();
    arm = 1'b0; in_valid = 1'b0;
    check("ovr arm wins", 32'(overrun), 32'd0);
    check("ovr arm wins x", 32'(x_count), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ovr after abort", 32'(overrun), 32'd0);
    check("ovr abort busy", 32'(busy), 32'd0);

    // Abort after six transfers
    arm_it("ab");
    for (int i = 0; i < 6; i++) send(24'h20_0000 + 24'(i), i);
    check("ab x before", 32'(x_count), 32'd2);
    check("ab y before", 32'(y_count), 32'd1);
    in_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab busy", 32'(busy), 32'd0);
    check("ab in_ready", 32'(in_ready), 32'd0);
    check("ab frame_done", 32'(frame_done), 32'd0);
    check("ab x", 32'(x_count), 32'd2);
    check("ab y", 32'(y_count), 32'd1);
    tick();
    check("ab no done", 32'(frame_done), 32'd0);
    arm_it("ab rearm");
    check("ab rearm x", 32'(x_count), 32'd0);
    check("ab rearm y", 32'(y_count), 32'd0);
    build(1'b0, 24'h10_0000, 24'h00_0001);
    run_table("ab frame");
    readback("ab frame", N);

    // Checksum frame: pixels 1..16
    arm_it("cs");
    build(1'b0, 24'h00_0001, 24'h00_0001);
    run_table("cs");
`ifdef PIXEL_CAPTURE_CHECKSUM_EN
    check("cs hold", checksum, 32'd136);
`else
    check("cs hold", checksum, 32'd0);
`endif

    // Reset after ten transfers
    arm_it("rst");
    for (int i = 0; i < 10; i++) send(24'h30_0000 + 24'(i), i);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    check("rst x_count", 32'(x_count), 32'd0);
    check("rst y_count", 32'(y_count), 32'd0);
    check("rst rd_data", 32'(rd_data), 32'd0);
    check("rst checksum", checksum, 32'd0);
    readback("rst mem", N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
